seg7_scanner: RTL and testbench
===============================

# seg7_scanner

Multiplexed seven-segment display driver for the lab board, fed directly by the clock divider's `clk_div` output. It runs entirely in the `clk_in` domain and treats the divider output as a slow strobe: it synchronizes and edge-detects that strobe, then scans one digit per strobe edge. Each frame shows a tear-free snapshot of a 32-bit value, typically a PC or register tap, as hex digits, with a short anode-off blanking gap between digits to suppress ghosting.

## Interface
- `NUM_DIGITS`, default 8: digits scanned, legal range 1..8.
- `BLANK_CYCLES`, default 2: `clk_in` cycles with all anodes off after each digit advance, legal range 0..15.

- `clk_in`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scan_clk`  in  1  divided clock from the divider; sampled as data, never used as a clock.
- `data`  in  4*NUM_DIGITS  hex value; digit i is `data[4i+3:4i]`.
- `data_valid`  in  1  one-cycle strobe; captures `data` and `dp_mask`.
- `dp_mask`  in  NUM_DIGITS  1 lights the decimal point of digit i.
- `an_n`  out  NUM_DIGITS  active-low anode enables, at most one low at a time.
- `seg_n`  out  7  active-low segments, order {g,f,e,d,c,b,a}.
- `dp_n`  out  1  active-low decimal point.
- `frame_done`  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- **Strobe path:** `scan_clk` passes through two synchronizer flops, then one edge flop. `tick` = sync2 & ~edge, a single `clk_in` cycle per rising edge.
- **Shadow register:** `data_valid` loads `data` and `dp_mask` into the shadow register at any time.
- **Active register:** loaded from the shadow only on a wrapping tick, so a frame never mixes old and new values.
  - `data_valid` in the same cycle as a wrapping tick: the active register takes the incoming `data` directly (bypass), and the shadow also updates.
- **Digit index `idx`:** advances on each tick. `NUM_DIGITS-1` wraps to 0.
- **Blanking:** on each tick, the blank counter loads `BLANK_CYCLES`. While it is nonzero, `an_n` is all ones. At zero, `an_n[idx]` = 0.
- **Tick during blanking:** still advances `idx` and reloads the counter; no tick is ever dropped.
- **Segment outputs:** `seg_n` / `dp_n` always reflect the active digit `idx` (hex decode, plus `~dp_mask[idx]`), registered.
- **Decode values:** 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.

## Timing
- **Reset** (asynchronous, immediate): `an_n` all ones, `seg_n`=1111111, `dp_n`=1, `frame_done`=0. `idx`=0, blank counter 0, shadow/active/synchronizers 0.
- **Out of reset:** digit 0 is lit from the first cycle, showing 0.
- **Strobe latency:** a `scan_clk` rise produces `tick` 2–3 `clk_in` cycles later.
- **Digit advance,** with `tick` high in cycle T:
  - T+1: `idx`, `seg_n` and `dp_n` show the new digit; `an_n` is all ones.
  - T+1+BLANK_CYCLES: the new anode goes low. With `BLANK_CYCLES`=0, this is T+1.
- **Frame boundary:** `frame_done` = 1 at T+1 when `idx` becomes 0, the same cycle the active register reloads.
- **Reset mid-scan:** anodes go off combinationally through the asynchronous clear. Scanning restarts at digit 0.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero suppression.
  - Digits above the most significant nonzero nibble of the active register keep `an_n` all ones for their whole slot.
  - Digit 0 is always shown, so a value of 0 displays "0".
  - A set `dp_mask` bit on a suppressed digit is also suppressed.
  - Timing is otherwise unchanged.
- `SEG7_LZ_BLANK_EN` undefined: every digit is shown, including leading zeros.

## Structure
- **Package `seg7_pkg`:** segment bit-order constants, the 16-entry hex-to-segment constant table, and the maximum-digit constant (8).
- **Sub-module `seg7_decoder`:** combinational 4-bit hex to active-low 7-segment decoder, instantiated once on the active digit.
- **Top level:** synchronizer, edge detect, index/blank counters, shadow/active registers, leading-zero logic.

## Test plan
- Reset, then `data`=0x12345678 + `data_valid`, then drive 8 `scan_clk` edges → digits 0..7 show 8,7,…,1; one `frame_done` per wrap; the new value appears only after the first wrap.
- `BLANK_CYCLES`=2, one tick at T → `an_n` all ones during T+1..T+2; `an_n[idx]` low at T+3; never two anodes low at once.
- `data_valid` with 0xAAAA0000 in the same cycle as a wrapping tick → the frame starting at digit 0 shows 0xAAAA0000, with no intervening old frame.
- Assert `rst_n` low mid-scan with `idx`=5 → `an_n`=11111111 and `seg_n`=1111111 immediately; after release, digit 0 scans first.
- With `SEG7_LZ_BLANK_EN`, `data`=0x000000F0 → only digits 0 and 1 ever light (0 and F); `data`=0 → only digit 0 lights, showing 1000000.
- `dp_mask`=0x01 → `dp_n`=0 only while `idx`=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: segment table, widths, digit limit.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package seg7_pkg;
  localparam int MAX_DIGITS = 8;
  localparam int IDX_W      = $clog2(MAX_DIGITS);
  localparam int SEG_W      = 7;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg_n
);
  assign seg_n = HEX_SEG[hex];
endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed hex display scanner driven by a synchronized scan_clk strobe.
// Define SEG7_LZ_BLANK_EN to suppress leading-zero digits.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    scan_clk,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    data_valid,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [SEG_W-1:0]        seg_n,
  output logic                    dp_n,
  output logic                    frame_done
);
  logic sync1_q, sync2_q, edge_q, tick, wrap;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [3:0]       blank_q, blank_nxt;
  logic [NUM_DIGITS-1:0][3:0] shadow_q, active_q, active_nxt;
  logic [NUM_DIGITS-1:0]      shadow_dp_q, active_dp_q, active_dp_nxt;
  logic [NUM_DIGITS-1:0]      an_nxt;
  logic [SEG_W-1:0]           dec_seg;
  logic                       lz_hide;

  assign tick = sync2_q & ~edge_q;
  assign wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Outputs are registered from next-state values so idx, segments and
  // anodes all move together in the cycle after the tick.
  always_comb begin
    idx_nxt       = idx_q;
    blank_nxt     = (blank_q != 4'd0) ? blank_q - 4'd1 : 4'd0;
    active_nxt    = active_q;
    active_dp_nxt = active_dp_q;
    if (tick) begin
      idx_nxt   = wrap ? '0 : idx_q + 1'b1;
      blank_nxt = 4'(BLANK_CYCLES);
    end
    if (wrap) begin
      active_nxt    = data_valid ? data    : shadow_q;
      active_dp_nxt = data_valid ? dp_mask : shadow_dp_q;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  // Hidden when every nibble from this digit upward is zero; digit 0 never hides.
  always_comb begin
    lz_hide = (idx_nxt != '0);
    for (int j = 0; j < NUM_DIGITS; j++)
      if (IDX_W'(j) >= idx_nxt && active_nxt[j] != 4'h0) lz_hide = 1'b0;
  end
`else
  assign lz_hide = 1'b0;
`endif

  always_comb begin
    an_nxt = '1;
    if (blank_nxt == 4'd0 && !lz_hide) an_nxt[idx_nxt] = 1'b0;
  end

  seg7_decoder u_dec (
    .hex   (active_nxt[idx_nxt]),
    .seg_n (dec_seg)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      edge_q      <= 1'b0;
      idx_q       <= '0;
      blank_q     <= 4'd0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      active_q    <= '0;
      active_dp_q <= '0;
      an_n        <= '1;
      seg_n       <= SEG_OFF;
      dp_n        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      sync1_q     <= scan_clk;
      sync2_q     <= sync1_q;
      edge_q      <= sync2_q;
      idx_q       <= idx_nxt;
      blank_q     <= blank_nxt;
      active_q    <= active_nxt;
      active_dp_q <= active_dp_nxt;
      if (data_valid) begin
        shadow_q    <= data;
        shadow_dp_q <= dp_mask;
      end
      an_n       <= an_nxt;
      seg_n      <= dec_seg;
      dp_n       <= ~(active_dp_nxt[idx_nxt] & ~lz_hide);
      frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_seg7_scanner.sv
// Directed bench for seg7_scanner (NUM_DIGITS=8, BLANK_CYCLES=2).
module tb_seg7_scanner;
  logic        clk_in = 1'b0;
  logic        rst_n = 1'b1;
  logic        scan_clk = 1'b0;
  logic [31:0] data = '0;
  logic        data_valid = 1'b0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  int vectors = 0;
  int errs = 0;

  seg7_scanner #(.NUM_DIGITS(8), .BLANK_CYCLES(2)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .scan_clk(scan_clk), .data(data),
    .data_valid(data_valid), .dp_mask(dp_mask), .an_n(an_n), .seg_n(seg_n),
    .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  function automatic logic [7:0] exp_an(input int i, input logic [31:0] v);
    logic [7:0] a;
    a = 8'hFF;
`ifdef SEG7_LZ_BLANK_EN
    if (i != 0 && (v >> (4 * i)) == 32'd0) return a;
`endif
    a[i] = 1'b0;
    return a;
  endfunction

  task automatic load(input logic [31:0] d, input logic [7:0] m);
    data = d; dp_mask = m; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  // One scan_clk rise; tick lands in the cycle after the second sync edge.
  task automatic scan_edge(input logic [31:0] val, input int idx, input logic [6:0] eseg,
                           input logic edp, input logic efd, input logic byp,
                           input logic [31:0] bdata);
    scan_clk = 1'b1;
    step(); step();
    if (byp) begin data = bdata; dp_mask = 8'h00; data_valid = 1'b1; end
    step();
    data_valid = 1'b0;
    chk($sformatf("an_blank1_d%0d", idx), an_n, 8'hFF);
    chk($sformatf("seg_d%0d", idx), seg_n, eseg);
    chk($sformatf("dp_d%0d", idx), dp_n, edp);
    chk($sformatf("fd_d%0d", idx), frame_done, efd);
    step();
    chk($sformatf("an_blank2_d%0d", idx), an_n, 8'hFF);
    chk($sformatf("fd_low_d%0d", idx), frame_done, 1'b0);
    step();
    chk($sformatf("an_lit_d%0d", idx), an_n, exp_an(idx, val));
    chk($sformatf("seg_hold_d%0d", idx), seg_n, eseg);
    scan_clk = 1'b0;
    step(); step(); step();
  endtask

  logic [6:0] f2 [7];
  logic [6:0] f3 [5];

  initial begin
    f2 = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    f3 = '{7'h40, 7'h40, 7'h40, 7'h08, 7'h08};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_an", an_n, 8'hFF);
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_dp", dp_n, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    rst_n = 1'b1;
    step();
    chk("boot_an", an_n, 8'hFE);
    chk("boot_seg", seg_n, 7'h40);
    chk("boot_dp", dp_n, 1'b1);

    load(32'h12345678, 8'h01);
    chk("shadow_not_shown", seg_n, 7'h40);

    for (int i = 1; i < 8; i++) scan_edge(32'h0, i, 7'h40, 1'b1, 1'b0, 1'b0, '0);
    scan_edge(32'h12345678, 0, 7'h00, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 1; i < 8; i++) scan_edge(32'h12345678, i, f2[i-1], 1'b1, 1'b0, 1'b0, '0);

    // Load coincides with the wrapping tick: new value shows straight away.
    scan_edge(32'hAAAA0000, 0, 7'h40, 1'b1, 1'b1, 1'b1, 32'hAAAA0000);
    for (int i = 1; i < 6; i++) scan_edge(32'hAAAA0000, i, f3[i-1], 1'b1, 1'b0, 1'b0, '0);

    #2 rst_n = 1'b0;
    #1;
    chk("midrst_an", an_n, 8'hFF);
    chk("midrst_seg", seg_n, 7'h7F);
    chk("midrst_dp", dp_n, 1'b1);
    #1 rst_n = 1'b1;
    step();
    chk("restart_an", an_n, 8'hFE);
    chk("restart_seg", seg_n, 7'h40);
    scan_edge(32'h0, 1, 7'h40, 1'b1, 1'b0, 1'b0, '0);

`ifdef SEG7_LZ_BLANK_EN
    load(32'h000000F0, 8'h00);
    for (int i = 2; i < 8; i++) scan_edge(32'h0, i, 7'h40, 1'b1, 1'b0, 1'b0, '0);
    scan_edge(32'h000000F0, 0, 7'h40, 1'b1, 1'b1, 1'b0, '0);
    scan_edge(32'h000000F0, 1, 7'h0E, 1'b1, 1'b0, 1'b0, '0);
    load(32'h0, 8'hFF);
    for (int i = 2; i < 8; i++) scan_edge(32'h000000F0, i, 7'h40, 1'b1, 1'b0, 1'b0, '0);
    scan_edge(32'h0, 0, 7'h40, 1'b0, 1'b1, 1'b0, '0);
    scan_edge(32'h0, 1, 7'h40, 1'b1, 1'b0, 1'b0, '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
